// File: rtl/interrupt_controller_if.sv
// Handshake and configuration bundle between the interrupt controller and its
// CPU/bus side. The controller uses the slave modport.
interface interrupt_controller_if #(
   parameter int INTERRUPT_WIDTH = 4,
   parameter int N_SOURCES       = 15
);
   logic [N_SOURCES-1:0]       irq_in;
   logic                       processing_interrupt;
   logic                       restore_state;
   logic [INTERRUPT_WIDTH-1:0] interrupt;
   logic                       cfg_we;
   logic [1:0]                 cfg_addr;
   logic [N_SOURCES-1:0]       cfg_wdata;
   logic [N_SOURCES-1:0]       cfg_rdata;
   logic [INTERRUPT_WIDTH-1:0] in_service;

   modport master (
      output irq_in, processing_interrupt, restore_state, cfg_we, cfg_addr, cfg_wdata,
      input  interrupt, cfg_rdata, in_service
   );

   modport slave (
      input  irq_in, processing_interrupt, restore_state, cfg_we, cfg_addr, cfg_wdata,
      output interrupt, cfg_rdata, in_service
   );
endinterface

// File: rtl/interrupt_controller.sv
// Edge-triggered, maskable interrupt source for the CPU control FSM: latches
// pending requests and holds the committed ID stable until the handler returns.
module interrupt_controller #(
   parameter int INTERRUPT_WIDTH = 4,
   parameter int N_SOURCES       = 15
) (
   input logic                   clk,
   input logic                   rst,
   interrupt_controller_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      ACTIVE  = 2'd2
   } state_t;

   logic [N_SOURCES-1:0]       irq_meta_p0;
   logic [N_SOURCES-1:0]       irq_sync_p1;
   logic [N_SOURCES-1:0]       irq_prev_p2;
   logic [N_SOURCES-1:0]       irq_rise;
   logic [N_SOURCES-1:0]       mask;
   logic [N_SOURCES-1:0]       pending;
   logic [N_SOURCES-1:0]       enabled;
   logic [N_SOURCES-1:0]       sw_set;
   logic [N_SOURCES-1:0]       sw_clr;
   logic [N_SOURCES-1:0]       ack_clr;
   logic [N_SOURCES-1:0]       status;
   logic [INTERRUPT_WIDTH-1:0] win_id;
   logic [INTERRUPT_WIDTH-1:0] in_service;
   logic                       proc_prev;
   logic                       ack;
   state_t                     state;
   state_t                     state_nxt;

   // Stage p0/p1: two-flop synchroniser; stage p2: previous value for edge detect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_meta_p0 <= '0;
         irq_sync_p1 <= '0;
         irq_prev_p2 <= '0;
      end else begin
         irq_meta_p0 <= bus.irq_in;
         irq_sync_p1 <= irq_meta_p0;
         irq_prev_p2 <= irq_sync_p1;
      end
   end

   assign irq_rise = irq_sync_p1 & ~irq_prev_p2;
   assign sw_set   = (bus.cfg_we && bus.cfg_addr == 2'd2) ? bus.cfg_wdata : '0;
   assign sw_clr   = (bus.cfg_we && bus.cfg_addr == 2'd1) ? bus.cfg_wdata : '0;
   assign ack      = (state == REQUEST) && bus.processing_interrupt && !proc_prev;
   assign enabled  = pending & mask;

   always_comb begin
      win_id  = '0;
      ack_clr = '0;
      for (int i = N_SOURCES - 1; i >= 0; i--) begin
         if (enabled[i]) win_id = INTERRUPT_WIDTH'(i + 1);
         ack_clr[i] = ack && (in_service == INTERRUPT_WIDTH'(i + 1));
      end
   end

   // Sets are OR-ed in after clears so a same-cycle set always survives
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask      <= '0;
         pending   <= '0;
         proc_prev <= 1'b0;
      end else begin
         if (bus.cfg_we && bus.cfg_addr == 2'd0) mask <= bus.cfg_wdata;
         pending   <= (pending & ~(sw_clr | ack_clr)) | irq_rise | sw_set;
         proc_prev <= bus.processing_interrupt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|enabled) state_nxt = REQUEST;
         REQUEST: if (ack) state_nxt = ACTIVE;
         ACTIVE:  if (bus.restore_state) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The ID is captured once on leaving IDLE and frozen until the handler returns
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_service <= '0;
      end else if (state == IDLE && |enabled) begin
         in_service <= win_id;
      end else if (state == ACTIVE && bus.restore_state) begin
         in_service <= '0;
      end
   end

   always_comb begin
      status = '0;
      status[INTERRUPT_WIDTH+1:0] = {in_service, state};
      bus.interrupt  = (state == IDLE) ? '0 : in_service;
      bus.in_service = in_service;
      case (bus.cfg_addr)
         2'd0:    bus.cfg_rdata = mask;
         2'd1:    bus.cfg_rdata = pending;
         2'd3:    bus.cfg_rdata = status;
         default: bus.cfg_rdata = '0;
      endcase
   end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Interrupt source side of the CPU interrupt handshake. Collects up to N_SOURCES peripheral request lines, applies per-source masking, and latches pending requests. It presents the highest-priority enabled request to the CPU control FSM as a nonzero encoded ID on `interrupt`, which the FSM uses to form the vector as 7*ID. It tracks the FSM's `processing_interrupt` / `restore_state` handshake so that an ID stays stable until the handler returns.

Parameters:
INTERRUPT_WIDTH, 4, width of encoded ID bus to the CPU; ID 0 means "no request".
N_SOURCES, 15, number of request sources; must be at most 2**INTERRUPT_WIDTH-1. Source i maps to ID i+1.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
irq_in  in  N_SOURCES  raw asynchronous peripheral request lines, rising-edge triggered
processing_interrupt  in  1  from CPU FSM; goes high when the FSM accepts a request
restore_state  in  1  from CPU FSM; one-cycle pulse on return from interrupt
interrupt  out  INTERRUPT_WIDTH  encoded ID to CPU FSM; 0 = none
cfg_we  in  1  config write strobe
cfg_addr  in  2  register select: 0 MASK, 1 PENDING, 2 SWTRIG, 3 STATUS
cfg_wdata  in  N_SOURCES  config write data
cfg_rdata  out  N_SOURCES  combinational readback of the selected register
in_service  out  INTERRUPT_WIDTH  ID currently committed or being serviced; 0 when IDLE

Behaviour:
- Reset (asynchronous, active-high): all of the following clear to 0 immediately:
  - mask, pending, sync/edge flops, in_service, interrupt
  - state returns to IDLE
  - reset mid-handler abandons the handler with no further outputs
- Synchronisation: irq_in passes through a 2-flop synchroniser plus a previous-value flop.
  - A request sampled high at edge k sets its pending bit at edge k+2 (synced=1, prev=0).
  - Holding a line high does not re-trigger.
- MASK (addr 0): read/write; bit=1 enables the source. Masked sources still latch pending but are not selected.
- PENDING (addr 1): read returns pending bits; write-1-to-clear.
- SWTRIG (addr 2): write-1-to-set pending, effective at the write edge; reads as 0.
- STATUS (addr 3): read returns {in_service, state[1:0]} zero-extended.
- Set/clear collision: a hardware edge or SWTRIG set on the same cycle as a clear leaves the bit set.
- Priority: among (pending & mask), the lowest index wins, giving ID = index+1.
- FSM states (2-bit encoding: IDLE=0, REQUEST=1, ACTIVE=2):
  - IDLE: interrupt=0. If any enabled pending bit exists, register the winning ID into in_service and interrupt, then go to REQUEST. Output is visible one cycle after pending is set, so raw edge to `interrupt` takes 3 cycles.
  - REQUEST: interrupt holds in_service. The ID is committed: later mask changes, PENDING clears, or higher-priority arrivals do not change it. On the edge where processing_interrupt=1 and its registered previous value=0, clear that source's pending bit and go to ACTIVE.
  - ACTIVE: interrupt keeps holding in_service, because the FSM samples the ID one cycle after raising processing_interrupt. New edges, including from the same source, set pending normally. On restore_state=1, go to IDLE with interrupt=0 and in_service=0 on the next cycle.
  - IDLE re-arbitration: no earlier than the cycle after IDLE is entered.
- Spurious handshake inputs:
  - restore_state outside ACTIVE is ignored.
  - processing_interrupt already high on entry to REQUEST does not count as an ack; a fresh rising edge is required.
- cfg writes are honoured in every state.

Test Plan:
1. Reset, MASK=0x0001, pulse irq_in[0] high 3 cycles -> pending[0]=1 two edges after the first sample; interrupt=1 one cycle later; STATUS state=REQUEST.
2. irq_in[3] and irq_in[1] rise the same cycle, MASK=0x000A -> interrupt=2; after ack and restore_state, interrupt=0 for one cycle, then 4.
3. In REQUEST with ID 2, write MASK=0 and PENDING clear 0x0002 -> interrupt stays 2 through ack and ACTIVE until restore_state.
4. In ACTIVE for ID 1, irq_in[0] rises again -> pending[0]=1 while interrupt still 1; after restore_state, IDLE, then interrupt=1 again.
5. SWTRIG write 0x0010 with MASK=0x0010 -> pending[4]=1 at the write edge, interrupt=5 next edge; restore_state pulse issued in IDLE beforehand has no effect.
6. Assert rst asynchronously in ACTIVE -> interrupt, in_service and pending read 0 before the next clock edge; state IDLE.
